// File: rtl/mul_pkg.sv
// mul_pkg: decode constants and sequencer state type shared by the EX-stage multiplier and ALU decoder.
package mul_pkg;
   localparam logic [10:0] FUNCT_MUL   = 11'b10011011000;
   localparam logic [10:0] FUNCT_UMULH = 11'b10011011110;
   localparam logic [1:0]  ALUOP_RTYPE = 2'b10;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add multiply iteration; the carry out of the upper add re-enters at the product MSB.
module mul_step #(
   parameter int N = 64
) (
   input  logic [2*N-1:0] prod_i,
   input  logic [N-1:0]   mcand_i,
   output logic [2*N-1:0] prod_o
);
   logic [N:0] sum;
   always_comb begin
      sum    = {1'b0, prod_i[2*N-1:N]} + (prod_i[0] ? {1'b0, mcand_i} : '0);
      prod_o = {sum, prod_i[N-1:1]};
   end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: detects MUL/UMULH in EX, runs a fixed N-step shift-add and stalls the pipeline until done.
module mul_sequencer
   import mul_pkg::*;
#(
   parameter  int N  = 64,
   localparam int CW = $clog2(N) + 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ex_valid_i,
   input  logic         flush_i,
   input  logic [1:0]   aluop_i,
   input  logic [10:0]  funct_i,
   input  logic [N-1:0] op_a_i,
   input  logic [N-1:0] op_b_i,
   output logic         stall_o,
   output logic         busy_o,
   output logic [N-1:0] result_o,
   output logic         result_valid_o
);
   mul_state_t     state_q, state_d;
   logic [2*N-1:0] prod_q, prod_d, prod_step;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]  count_q, count_d;
   logic           hi_sel_q, hi_sel_d;
   logic           is_mul, last, valid;

   assign is_mul = ex_valid_i & ~flush_i & (aluop_i == ALUOP_RTYPE)
                 & ((funct_i == FUNCT_MUL) | (funct_i == FUNCT_UMULH));
   assign last   = count_q == CW'(1);

   mul_step #(.N(N)) u_step (
      .prod_i  (prod_q),
      .mcand_i (mcand_q),
      .prod_o  (prod_step)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         prod_q   <= '0;
         mcand_q  <= '0;
         count_q  <= '0;
         hi_sel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         count_q  <= count_d;
         hi_sel_q <= hi_sel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      count_d  = count_q;
      hi_sel_d = hi_sel_q;
      case (state_q)
         IDLE: if (is_mul) begin
            state_d  = RUN;
            mcand_d  = op_a_i;
            prod_d   = {{N{1'b0}}, op_b_i};
            count_d  = CW'(N);
            hi_sel_d = funct_i == FUNCT_UMULH;
         end
         RUN: begin
            prod_d  = prod_step;
            count_d = count_q - CW'(1);
            state_d = flush_i ? IDLE : (last ? DONE : RUN);
         end
         default: state_d = IDLE;
      endcase
   end

   // stall is gated by reset so a held multiply encoding cannot raise it while in reset
   always_comb begin
      valid          = (state_q == DONE) & ~flush_i;
      stall_o        = rst_ni & ((state_q == IDLE) ? is_mul : ((state_q == RUN) & ~flush_i));
      busy_o         = state_q != IDLE;
      result_valid_o = valid;
      result_o       = valid ? (hi_sel_q ? prod_q[2*N-1:N] : prod_q[N-1:0]) : '0;
   end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: randomized and directed checks of mul_sequencer against a plain-arithmetic product model.
module tb_mul_sequencer;
   localparam int N = 64;
   localparam logic [10:0] F_MUL   = 11'b10011011000;
   localparam logic [10:0] F_UMULH = 11'b10011011110;
   localparam logic [10:0] F_ADD   = 11'b10001011000;

   logic         clk_i = 1'b0, rst_ni = 1'b0, ex_valid_i = 1'b0, flush_i = 1'b0;
   logic [1:0]   aluop_i = '0;
   logic [10:0]  funct_i = '0;
   logic [N-1:0] op_a_i = '0, op_b_i = '0;
   logic         stall_o, busy_o, result_valid_o;
   logic [N-1:0] result_o;
   int           n_cmp = 0, n_bad = 0;

   always #5 clk_i = ~clk_i;

   mul_sequencer #(.N(N)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .ex_valid_i     (ex_valid_i),
      .flush_i        (flush_i),
      .aluop_i        (aluop_i),
      .funct_i        (funct_i),
      .op_a_i         (op_a_i),
      .op_b_i         (op_b_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o)
   );

   function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input bit hi);
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      return hi ? p[2*N-1:N] : p[N-1:0];
   endfunction

   function automatic logic [N-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic idle();
      ex_valid_i = 1'b0;
      flush_i    = 1'b0;
      aluop_i    = 2'b00;
      funct_i    = '0;
   endtask

   task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input bit hi);
      ex_valid_i = 1'b1;
      flush_i    = 1'b0;
      aluop_i    = 2'b10;
      funct_i    = hi ? F_UMULH : F_MUL;
      op_a_i     = a;
      op_b_i     = b;
   endtask

   // Drives one multiply and reports stall at issue, cycles until result_valid, stall coverage and result.
   task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b, input bit hi, input bit scramble,
                         output logic st0, output int lat, output bit stall_ok, output logic [N-1:0] res);
      start(a, b, hi);
      #1 st0 = stall_o;
      lat = 0;
      stall_ok = 1'b1;
      res = 'x;
      while (lat < N + 8) begin
         @(negedge clk_i);
         lat++;
         if (result_valid_o === 1'b1) begin
            res = result_o;
            break;
         end
         if (stall_o !== 1'b1) stall_ok = 1'b0;
         if (scramble) begin
            op_a_i  = rnd64();
            op_b_i  = rnd64();
            funct_i = $urandom_range(1) ? F_UMULH : F_MUL;
         end
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle();
      repeat (2) @(negedge clk_i);
      n_cmp++; if ({stall_o, busy_o, result_valid_o} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got=%b want=000", {stall_o, busy_o, result_valid_o}); end
      n_cmp++; if (result_o !== '0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result_o); end
      start(64'd3, 64'd5, 1'b0);
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall_held got=%b want=0", stall_o); end
      idle();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_basic();
      logic st0; int lat; bit ok; logic [N-1:0] res;
      @(negedge clk_i);
      do_mul(64'd3, 64'd5, 1'b0, 1'b0, st0, lat, ok, res);
      n_cmp++; if (st0 !== 1'b1) begin n_bad++; $display("FAIL basic_stall_T got=%b want=1", st0); end
      n_cmp++; if (lat != N + 1) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, N + 1); end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_stall_run got=0 want=1"); end
      n_cmp++; if (res !== 64'd15) begin n_bad++; $display("FAIL basic_result got=%h want=%h", res, 64'd15); end
      n_cmp++; if ({stall_o, busy_o} !== 2'b01) begin n_bad++; $display("FAIL basic_done_ctl got=%b want=01", {stall_o, busy_o}); end
      idle();
      @(negedge clk_i);
      n_cmp++; if ({stall_o, busy_o, result_valid_o} !== 3'b000) begin n_bad++; $display("FAIL basic_idle got=%b want=000", {stall_o, busy_o, result_valid_o}); end
      n_cmp++; if (result_o !== '0) begin n_bad++; $display("FAIL basic_idle_result got=%h want=0", result_o); end
   endtask

   task automatic test_directed();
      logic [N-1:0] ta[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 64'd0};
      logic [N-1:0] tb[5] = '{64'd2, 64'd2, 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      bit           th[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic st0; int lat; bit ok; logic [N-1:0] res, exp;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         do_mul(ta[i], tb[i], th[i], 1'b0, st0, lat, ok, res);
         exp = model(ta[i], tb[i], th[i]);
         n_cmp++; if (lat != N + 1) begin n_bad++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, N + 1); end
         n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL directed%0d_result got=%h want=%h", i, res, exp); end
         idle();
      end
   endtask

   task automatic test_random();
      logic st0; int lat; bit ok; logic [N-1:0] a, b, res, exp; bit hi;
      for (int i = 0; i < 6; i++) begin
         a = rnd64(); b = rnd64(); hi = 1'($urandom_range(1));
         @(negedge clk_i);
         do_mul(a, b, hi, 1'b1, st0, lat, ok, res);
         exp = model(a, b, hi);
         n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL random%0d_result hi=%0d got=%h want=%h", i, hi, res, exp); end
         n_cmp++; if (lat != N + 1 || !ok) begin n_bad++; $display("FAIL random%0d_timing got=%0d/%0d want=%0d/1", i, lat, ok, N + 1); end
         idle();
      end
   endtask

   task automatic test_no_accept();
      logic [10:0] f[4] = '{F_ADD, F_MUL, F_MUL, F_UMULH};
      logic        v[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0]  o[4] = '{2'b10, 2'b10, 2'b00, 2'b10};
      logic        fl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      bit          seen;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         ex_valid_i = v[i]; aluop_i = o[i]; funct_i = f[i]; flush_i = fl[i];
         op_a_i = rnd64(); op_b_i = rnd64();
         seen = 1'b0;
         for (int c = 0; c < 4; c++) begin
            #1 if (stall_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
            @(negedge clk_i);
         end
         n_cmp++; if (seen) begin n_bad++; $display("FAIL no_accept%0d got=stall/busy want=quiet", i); end
         idle();
      end
   endtask

   task automatic test_flush();
      int  ks[2] = '{20, N};
      bit  seen;
      logic st0; int lat; bit ok; logic [N-1:0] res, a, b;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         start(rnd64(), rnd64(), 1'b0);
         repeat (ks[i]) @(negedge clk_i);
         flush_i = 1'b1;
         #1;
         n_cmp++; if ({stall_o, result_valid_o} !== 2'b00) begin n_bad++; $display("FAIL flush%0d_same got=%b want=00", ks[i], {stall_o, result_valid_o}); end
         @(negedge clk_i);
         n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL flush%0d_idle got=%b want=0", ks[i], busy_o); end
         idle();
         seen = 1'b0;
         for (int c = 0; c < N + 4; c++) begin
            @(negedge clk_i);
            if (result_valid_o !== 1'b0) seen = 1'b1;
         end
         n_cmp++; if (seen) begin n_bad++; $display("FAIL flush%0d_no_valid got=1 want=0", ks[i]); end
      end
      a = rnd64(); b = rnd64();
      @(negedge clk_i);
      do_mul(a, b, 1'b0, 1'b0, st0, lat, ok, res);
      n_cmp++; if (res !== model(a, b, 1'b0) || lat != N + 1) begin n_bad++; $display("FAIL flush_followup got=%h/%0d want=%h/%0d", res, lat, model(a, b, 1'b0), N + 1); end
      idle();
   endtask

   task automatic test_async_reset();
      @(negedge clk_i);
      start(rnd64(), rnd64(), 1'b1);
      repeat (30) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++; if ({stall_o, busy_o, result_valid_o} !== 3'b000 || result_o !== '0) begin n_bad++; $display("FAIL async_reset got=%b/%h want=000/0", {stall_o, busy_o, result_valid_o}, result_o); end
      @(negedge clk_i);
      idle();
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL async_release got=%b want=0", busy_o); end
   endtask

   task automatic test_back_to_back();
      logic st0; int lat; bit ok; logic [N-1:0] res, a1, b1, a2, b2;
      a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
      @(negedge clk_i);
      do_mul(a1, b1, 1'b0, 1'b0, st0, lat, ok, res);
      n_cmp++; if (res !== model(a1, b1, 1'b0) || lat != N + 1) begin n_bad++; $display("FAIL b2b_first got=%h/%0d want=%h/%0d", res, lat, model(a1, b1, 1'b0), N + 1); end
      do_mul(a2, b2, 1'b1, 1'b0, st0, lat, ok, res);
      n_cmp++; if (st0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_stall got=%b want=0", st0); end
      n_cmp++; if (lat != N + 2 || !ok) begin n_bad++; $display("FAIL b2b_second_timing got=%0d/%0d want=%0d/1", lat, ok, N + 2); end
      n_cmp++; if (res !== model(a2, b2, 1'b1)) begin n_bad++; $display("FAIL b2b_second got=%h want=%h", res, model(a2, b2, 1'b1)); end
      idle();
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_random();
      test_no_accept();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle controller for integer multiply in the EX stage of the pipelined LEGv8 core. It sits beside the ALU control decoder and detects R-type multiply encodings (MUL, UMULH) on the same funct/aluop inputs. It then runs an iterative shift-add sequence and holds the pipeline with a stall until the product is ready. The single-cycle ALU path is unchanged; this block takes over the EX result only for multiply.

Parameters:
N, 64, operand width in bits (power of two, >= 8)
CW, $clog2(N)+1, iteration counter width (derived; not overridden)

Ports:
clk  in  1  pipeline clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  EX stage holds a valid instruction
flush  in  1  EX stage squashed (branch taken); aborts any multiply
aluop  in  2  ALU op class from main decoder
funct  in  11  instruction bits [31:21]
op_a  in  N  multiplicand (Rn value after forwarding)
op_b  in  N  multiplier (Rm value after forwarding)
stall  out  1  freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM
busy  out  1  sequencer not in IDLE
result  out  N  MUL: product[N-1:0]; UMULH: product[2N-1:N]
result_valid  out  1  result holds the final value this cycle; EX mux selects result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; product, multiplicand, count and op-select cleared; stall=0, busy=0, result=0, result_valid=0.
- Decode: is_mul = ex_valid & ~flush & aluop==2'b10 & (funct==FUNCT_MUL 11'b10011011000 | funct==FUNCT_UMULH 11'b10011011110). All other encodings leave the block idle.
- States: IDLE, RUN, DONE.
- IDLE: stall = is_mul (combinational, same cycle). If is_mul: capture op_a into the multiplicand, load product = {N'b0, op_b}, count = N, latch hi_sel = (funct==FUNCT_UMULH), go to RUN.
- RUN: each cycle, if product[0] then upper = upper + multiplicand, with an N+1-bit sum so the carry is kept. Then shift the 2N-bit product right by 1 and take the carry into bit 2N-1. Decrement count. When count reaches 1 (last step), go to DONE. stall=1, busy=1.
- DONE: stall=0, result_valid=1, busy=1. The result is registered and stable. The ID/EX register advances at the end of this cycle. Always return to IDLE next cycle. A new multiply is never accepted in DONE, because the inputs still show the finishing instruction.
- Latency: accepted in cycle T. RUN occupies T+1..T+N. DONE is at T+N+1. stall is high for T..T+N (N+1 cycles).
- Fixed latency: op_b=0 or op_a=0 still takes N iterations. There is no early out.
- Operands are frozen at capture. Later changes on op_a/op_b/funct during RUN are ignored, except flush.
- flush in RUN or DONE: next state IDLE, no result_valid, stall drops in the same cycle. flush in IDLE blocks acceptance.
- Simultaneous flush and last RUN step: flush wins; no DONE.
- Reset mid-RUN: immediate return to IDLE with all outputs zero; the partial product is discarded.
- Arithmetic is unsigned. MUL low half is correct for signed operands too.
- result is 0 whenever result_valid=0.

Decomposition:
- Shared package mul_pkg: FUNCT_MUL, FUNCT_UMULH, ALUOP_RTYPE (2'b10), enum mul_state_t {IDLE, RUN, DONE}. aludec reuses ALUOP_RTYPE.
- One natural sub-module, mul_step: the combinational single iteration (product, multiplicand) -> next product. The FSM and counter stay in mul_sequencer.

Test Plan:
- Reset then MUL op_a=3, op_b=5 at T -> stall high T..T+64; at T+65 result_valid=1, result=15, stall=0; IDLE at T+66.
- MUL op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> result=0xFFFF_FFFF_FFFF_FFFE. Same operands with UMULH -> result=1.
- UMULH op_a=op_b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000. MUL with op_b=0 -> result=0 after the full 65-cycle latency.
- ADD funct 11'b10001011000 with aluop=10, and MUL encoding with ex_valid=0 -> stall never asserts, busy=0.
- MUL started, flush=1 at T+20 -> stall=0 that cycle, IDLE at T+21, result_valid never asserts. A following MUL is accepted normally.
- reset driven low at T+30 asynchronously, mid-clock -> stall, busy, result drop immediately. After release, a back-to-back MUL pair (second in EX at T+66) both complete with correct results.
